id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register directly downstream of the ID-stage control unit. Latches the
//  decoded control word (ALU op, S, shift_imm, mem size/enable/RW, load, RF enable,
//  branch, BL) and ID operands every cycle.
//  Detects load-use hazards against the instruction already in EX and inserts a bubble
//  (all-zero control, identical to a decoded NOP).
//  Squashes ID on a taken branch and holds on downstream wait.
// PARAMETERS
//  DATA_W  32  width of operand/datapath buses
//  CNT_W   16  width of saturating hazard-bubble counter
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high reset
//  id_alu_op       in   4       ALU opcode from control unit
//  id_s            in   1       update-flags bit
//  id_shift_imm    in   1       shifter-operand select
//  id_mem_size     in   2       memory access size
//  id_mem_enable   in   1       memory enable
//  id_mem_rw       in   1       memory RW (1=write)
//  id_load_inst    in   1       instruction is a load
//  id_rf_enable    in   1       register-file write enable
//  id_b_instr      in   1       branch instruction
//  id_b_l          in   1       branch-with-link
//  id_pa,id_pb,id_pd in DATA_W  RF read operands (Rn, Rm, Rd-for-store)
//  id_shift_field  in   12      I[11:0] shifter/offset field
//  id_rn,id_rm,id_rd in 4       register numbers of ID instruction
//  id_use_rn,id_use_rm in 1     ID instruction actually reads Rn / Rm
//  flush           in   1       taken branch: squash instruction entering EX
//  ex_hold         in   1       downstream wait: freeze EX contents
//  ex_* (same names/widths as id_* control, pa/pb/pd, shift_field, rd)  out  registered copies
//  ex_valid        out  1       EX holds a real (non-bubble) instruction
//  id_stall        out  1       comb.: freeze PC and IF/ID this cycle
//  hazard_count    out  CNT_W   number of load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset (async, any time incl. mid-hold): all ex_* = 0, ex_valid=0, hazard_count=0.
//    Stall/hazard are combinational outputs, so they read 0 while reset is held.
//  - hazard (comb.) = ex_valid & ex_load_inst & ex_rf_enable &
//    ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
//  - id_stall = (hazard & ~flush) | ex_hold.
//  - Next-state priority at each posedge:
//    1. ex_hold=1: all EX regs unchanged, counter unchanged. This applies even when flush=1;
//       the branch unit must keep flush asserted until hold drops.
//    2. flush=1: load bubble (controls 0, data 0, ex_valid=0); counter unchanged.
//    3. hazard=1: load bubble, ex_valid=0; hazard_count +1 unless all-ones (saturate).
//    4. Otherwise: load all id_* fields; ex_valid = 1 unless the whole incoming control word
//       is zero (NOP). The control word is {alu_op,s,shift_imm,mem_size,mem_enable,mem_rw,
//       load,rf_en,b,bl}.
//  - Latency: ID -> EX exactly 1 cycle when not stalled. A hazard costs exactly 1 bubble,
//    because after the bubble ex_valid=0 and hazard deasserts.
//  - Bubble never re-triggers hazard. A store (rf_enable=0) in EX never triggers hazard.
//  - Rd=R15 compares like any other register; no special case.
//  - No X on outputs after reset; data fields of bubbles are forced to 0.
// STRUCTURE
//  Shared package: control-word bit positions/width localparams, CTRL_BUBBLE=0,
//  ALU op constants (ADD=4'b0100, SUB=4'b0010), CNT_W default.
//  One sub-module: id_ex_hazard_detect (purely combinational hazard equation). Register
//  bank, priority mux and counter live in the top module.
// TESTING
//  1. Assert reset mid-stream with ex_valid=1 -> all ex_*, ex_valid and hazard_count read 0
//     immediately, before any clk edge.
//  2. Load R3 (load=1, rf_en=1, rd=3) followed by ADD reading rn=3 -> id_stall=1 for one
//     cycle; next cycle ex_valid=0 with alu_op=0; the ADD then enters EX; hazard_count=1.
//  3. Store (rf_en=0, rd=3) followed by a reader of R3 -> no stall, back-to-back
//     ex_valid=1.
//  4. flush=1 together with a hazard condition -> bubble loaded, id_stall=0,
//     hazard_count unchanged.
//  5. ex_hold=1 for 3 cycles with ADD in EX -> ex_* stable for 3 edges and id_stall=1;
//     hold+flush -> still held.
//  6. Preload hazard_count=2^CNT_W-1 (CNT_W=4 build, 15 hazards), then one more hazard ->
//     count stays 15.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-word layout,
// bubble encoding, ALU opcode constants and default widths.
package id_ex_stage_reg_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned REG_W      = 4;

    // Control word {alu_op,s,shift_imm,mem_size,mem_enable,mem_rw,load,rf_en,b,bl}
    localparam int unsigned CTRL_W            = 14;
    localparam int unsigned CTRL_BL           = 0;
    localparam int unsigned CTRL_B            = 1;
    localparam int unsigned CTRL_RF_EN        = 2;
    localparam int unsigned CTRL_LOAD         = 3;
    localparam int unsigned CTRL_MEM_RW       = 4;
    localparam int unsigned CTRL_MEM_EN       = 5;
    localparam int unsigned CTRL_MEM_SIZE_LSB = 6;
    localparam int unsigned CTRL_SHIFT_IMM    = 8;
    localparam int unsigned CTRL_S            = 9;
    localparam int unsigned CTRL_ALU_LSB      = 10;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded ID fields and pipeline controls in,
// registered EX copies, stall and hazard statistics out.
interface id_ex_stage_reg_if
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) ();
    logic [3:0]        id_alu_op, ex_alu_op;
    logic              id_s, ex_s;
    logic              id_shift_imm, ex_shift_imm;
    logic [1:0]        id_mem_size, ex_mem_size;
    logic              id_mem_enable, ex_mem_enable;
    logic              id_mem_rw, ex_mem_rw;
    logic              id_load_inst, ex_load_inst;
    logic              id_rf_enable, ex_rf_enable;
    logic              id_b_instr, ex_b_instr;
    logic              id_b_l, ex_b_l;
    logic [DATA_W-1:0] id_pa, id_pb, id_pd, ex_pa, ex_pb, ex_pd;
    logic [11:0]       id_shift_field, ex_shift_field;
    logic [REG_W-1:0]  id_rn, id_rm, id_rd, ex_rd;
    logic              id_use_rn, id_use_rm;
    logic              flush, ex_hold;
    logic              ex_valid, id_stall;
    logic [CNT_W-1:0]  hazard_count;

    modport master (
        output id_alu_op, id_s, id_shift_imm, id_mem_size, id_mem_enable, id_mem_rw,
               id_load_inst, id_rf_enable, id_b_instr, id_b_l, id_pa, id_pb, id_pd,
               id_shift_field, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, flush, ex_hold,
        input  ex_alu_op, ex_s, ex_shift_imm, ex_mem_size, ex_mem_enable, ex_mem_rw,
               ex_load_inst, ex_rf_enable, ex_b_instr, ex_b_l, ex_pa, ex_pb, ex_pd,
               ex_shift_field, ex_rd, ex_valid, id_stall, hazard_count
    );

    modport slave (
        input  id_alu_op, id_s, id_shift_imm, id_mem_size, id_mem_enable, id_mem_rw,
               id_load_inst, id_rf_enable, id_b_instr, id_b_l, id_pa, id_pb, id_pd,
               id_shift_field, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, flush, ex_hold,
        output ex_alu_op, ex_s, ex_shift_imm, ex_mem_size, ex_mem_enable, ex_mem_rw,
               ex_load_inst, ex_rf_enable, ex_b_instr, ex_b_l, ex_pa, ex_pb, ex_pd,
               ex_shift_field, ex_rd, ex_valid, id_stall, hazard_count
    );
endinterface

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module id_ex_hazard_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_load_inst,
    input  logic             ex_rf_enable,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    output logic             hazard
);
    assign hazard = ex_valid & ex_load_inst & ex_rf_enable &
                    ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash,
// downstream hold and a saturating count of inserted hazard bubbles.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    id_ex_stage_reg_if.slave   bus
);
    logic [CTRL_W-1:0] id_ctrl, ex_ctrl;
    logic [DATA_W-1:0] ex_pa, ex_pb, ex_pd;
    logic [11:0]       ex_shift_field;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_valid;
    logic [CNT_W-1:0]  hazard_count;
    logic              hazard;

    always_comb begin
        id_ctrl                                  = CTRL_BUBBLE;
        id_ctrl[CTRL_ALU_LSB +: 4]               = bus.id_alu_op;
        id_ctrl[CTRL_S]                          = bus.id_s;
        id_ctrl[CTRL_SHIFT_IMM]                  = bus.id_shift_imm;
        id_ctrl[CTRL_MEM_SIZE_LSB +: 2]          = bus.id_mem_size;
        id_ctrl[CTRL_MEM_EN]                     = bus.id_mem_enable;
        id_ctrl[CTRL_MEM_RW]                     = bus.id_mem_rw;
        id_ctrl[CTRL_LOAD]                       = bus.id_load_inst;
        id_ctrl[CTRL_RF_EN]                      = bus.id_rf_enable;
        id_ctrl[CTRL_B]                          = bus.id_b_instr;
        id_ctrl[CTRL_BL]                         = bus.id_b_l;
    end

    id_ex_hazard_detect u_hazard (
        .ex_valid     (ex_valid),
        .ex_load_inst (ex_ctrl[CTRL_LOAD]),
        .ex_rf_enable (ex_ctrl[CTRL_RF_EN]),
        .ex_rd        (ex_rd),
        .id_rn        (bus.id_rn),
        .id_rm        (bus.id_rm),
        .id_use_rn    (bus.id_use_rn),
        .id_use_rm    (bus.id_use_rm),
        .hazard       (hazard)
    );

    // Priority: hold > flush > hazard bubble > normal advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl        <= CTRL_BUBBLE;
            ex_pa          <= '0;
            ex_pb          <= '0;
            ex_pd          <= '0;
            ex_shift_field <= '0;
            ex_rd          <= '0;
            ex_valid       <= 1'b0;
            hazard_count   <= '0;
        end else if (!bus.ex_hold) begin
            if (bus.flush || hazard) begin
                ex_ctrl        <= CTRL_BUBBLE;
                ex_pa          <= '0;
                ex_pb          <= '0;
                ex_pd          <= '0;
                ex_shift_field <= '0;
                ex_rd          <= '0;
                ex_valid       <= 1'b0;
                if (!bus.flush && (hazard_count != '1))
                    hazard_count <= hazard_count + 1'b1;
            end else begin
                ex_ctrl        <= id_ctrl;
                ex_pa          <= bus.id_pa;
                ex_pb          <= bus.id_pb;
                ex_pd          <= bus.id_pd;
                ex_shift_field <= bus.id_shift_field;
                ex_rd          <= bus.id_rd;
                ex_valid       <= (id_ctrl != CTRL_BUBBLE);
            end
        end
    end

    // Gated by reset so a hold request cannot show a stall while the stage is cleared.
    assign bus.id_stall       = ~reset & ((hazard & ~bus.flush) | bus.ex_hold);

    assign bus.ex_alu_op      = ex_ctrl[CTRL_ALU_LSB +: 4];
    assign bus.ex_s           = ex_ctrl[CTRL_S];
    assign bus.ex_shift_imm   = ex_ctrl[CTRL_SHIFT_IMM];
    assign bus.ex_mem_size    = ex_ctrl[CTRL_MEM_SIZE_LSB +: 2];
    assign bus.ex_mem_enable  = ex_ctrl[CTRL_MEM_EN];
    assign bus.ex_mem_rw      = ex_ctrl[CTRL_MEM_RW];
    assign bus.ex_load_inst   = ex_ctrl[CTRL_LOAD];
    assign bus.ex_rf_enable   = ex_ctrl[CTRL_RF_EN];
    assign bus.ex_b_instr     = ex_ctrl[CTRL_B];
    assign bus.ex_b_l         = ex_ctrl[CTRL_BL];
    assign bus.ex_pa          = ex_pa;
    assign bus.ex_pb          = ex_pb;
    assign bus.ex_pd          = ex_pd;
    assign bus.ex_shift_field = ex_shift_field;
    assign bus.ex_rd          = ex_rd;
    assign bus.ex_valid       = ex_valid;
    assign bus.hazard_count   = hazard_count;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, reset/saturation sequences
// and random traffic against an instruction-level reference model.
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    id_ex_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        s, shift_imm;
        logic [1:0]  mem_size;
        logic        mem_enable, mem_rw, load, rf_en, b, bl;
        logic [31:0] pa, pb, pd;
        logic [11:0] sf;
        logic [3:0]  rn, rm, rd;
        logic        use_rn, use_rm;
    } instr_t;

    typedef struct {
        instr_t     i;
        logic       f, h;
        logic       stall, valid;
        logic [3:0] alu;
        int         cnt;
    } vec_t;

    instr_t m_ex;
    logic   m_valid;
    int     m_cnt;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t mk_ld(input logic [3:0] rd, input logic [3:0] rn);
        instr_t x = '0;
        x.alu_op = ALU_ADD; x.shift_imm = 1'b1; x.mem_size = 2'b10; x.mem_enable = 1'b1;
        x.load = 1'b1; x.rf_en = 1'b1; x.rd = rd; x.rn = rn; x.use_rn = 1'b1;
        x.pa = $urandom; x.pb = $urandom; x.pd = $urandom; x.sf = 12'h004;
        return x;
    endfunction

    function automatic instr_t mk_alu(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm);
        instr_t x = '0;
        x.alu_op = op; x.s = 1'b1; x.rf_en = 1'b1; x.rd = rd; x.rn = rn; x.rm = rm;
        x.use_rn = 1'b1; x.use_rm = 1'b1;
        x.pa = $urandom; x.pb = $urandom; x.pd = $urandom; x.sf = 12'($urandom);
        return x;
    endfunction

    function automatic instr_t mk_st(input logic [3:0] rd, input logic [3:0] rn);
        instr_t x = '0;
        x.alu_op = ALU_ADD; x.shift_imm = 1'b1; x.mem_size = 2'b10; x.mem_enable = 1'b1;
        x.mem_rw = 1'b1; x.rd = rd; x.rn = rn; x.use_rn = 1'b1;
        x.pa = $urandom; x.pb = $urandom; x.pd = $urandom; x.sf = 12'h008;
        return x;
    endfunction

    function automatic instr_t mk_rand();
        instr_t x;
        x = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        x.rn = 4'($urandom_range(0, 3));
        x.rm = 4'($urandom_range(0, 3));
        x.rd = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
            x.alu_op = '0; x.s = 0; x.shift_imm = 0; x.mem_size = '0; x.mem_enable = 0;
            x.mem_rw = 0; x.load = 0; x.rf_en = 0; x.b = 0; x.bl = 0;
        end
        return x;
    endfunction

    function automatic logic [127:0] bundle_of(input instr_t x);
        return 128'({x.alu_op, x.s, x.shift_imm, x.mem_size, x.mem_enable, x.mem_rw,
                     x.load, x.rf_en, x.b, x.bl, x.pa, x.pb, x.pd, x.sf, x.rd});
    endfunction

    function automatic logic [127:0] dut_bundle();
        return 128'({bus.ex_alu_op, bus.ex_s, bus.ex_shift_imm, bus.ex_mem_size,
                     bus.ex_mem_enable, bus.ex_mem_rw, bus.ex_load_inst, bus.ex_rf_enable,
                     bus.ex_b_instr, bus.ex_b_l, bus.ex_pa, bus.ex_pb, bus.ex_pd,
                     bus.ex_shift_field, bus.ex_rd});
    endfunction

    function automatic logic model_hazard(input instr_t x);
        return m_valid && m_ex.load && m_ex.rf_en &&
               ((x.use_rn && x.rn == m_ex.rd) || (x.use_rm && x.rm == m_ex.rd));
    endfunction

    task automatic drive(input instr_t x, input logic f, input logic h);
        bus.id_alu_op = x.alu_op; bus.id_s = x.s; bus.id_shift_imm = x.shift_imm;
        bus.id_mem_size = x.mem_size; bus.id_mem_enable = x.mem_enable;
        bus.id_mem_rw = x.mem_rw; bus.id_load_inst = x.load; bus.id_rf_enable = x.rf_en;
        bus.id_b_instr = x.b; bus.id_b_l = x.bl;
        bus.id_pa = x.pa; bus.id_pb = x.pb; bus.id_pd = x.pd; bus.id_shift_field = x.sf;
        bus.id_rn = x.rn; bus.id_rm = x.rm; bus.id_rd = x.rd;
        bus.id_use_rn = x.use_rn; bus.id_use_rm = x.use_rm;
        bus.flush = f; bus.ex_hold = h;
    endtask

    // Called 1 time unit after a rising edge; returns sampled id_stall.
    task automatic step(input instr_t x, input logic f, input logic h, input string tag,
                        output logic st);
        logic hz;
        drive(x, f, h);
        #3;
        hz = model_hazard(x);
        st = bus.id_stall;
        chk({tag, " id_stall"}, 128'(st), 128'((hz && !f) || h));
        @(posedge clk);
        #1;
        if (!h) begin
            if (f || hz) begin
                m_ex = '0;
                m_valid = 1'b0;
                if (!f) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            end else begin
                m_ex = x;
                m_valid = (bundle_of(x) >> 112) != 0;
            end
        end
        chk({tag, " ex_bundle"}, dut_bundle(), bundle_of(m_ex));
        chk({tag, " ex_valid"}, 128'(bus.ex_valid), 128'(m_valid));
        chk({tag, " hazard_count"}, 128'(bus.hazard_count), 128'(m_cnt));
    endtask

    vec_t   tbl[16];
    instr_t nop, add9, sub10;
    logic   st;

    initial begin
        nop = '0;
        add9 = mk_alu(ALU_ADD, 4'd9, 4'd3, 4'd2);
        sub10 = mk_alu(ALU_SUB, 4'd10, 4'd1, 4'd2);
        tbl[0]  = '{mk_ld(4'd3, 4'd1),                  0, 0, 0, 1, ALU_ADD, 0};
        tbl[1]  = '{mk_alu(ALU_ADD, 4'd5, 4'd3, 4'd2),  0, 0, 1, 0, 4'd0,    1};
        tbl[2]  = '{tbl[1].i,                           0, 0, 0, 1, ALU_ADD, 1};
        tbl[3]  = '{mk_st(4'd3, 4'd1),                  0, 0, 0, 1, ALU_ADD, 1};
        tbl[4]  = '{mk_alu(ALU_ADD, 4'd6, 4'd3, 4'd3),  0, 0, 0, 1, ALU_ADD, 1};
        tbl[5]  = '{mk_ld(4'd7, 4'd2),                  0, 0, 0, 1, ALU_ADD, 1};
        tbl[6]  = '{mk_alu(ALU_ADD, 4'd4, 4'd7, 4'd1),  1, 0, 0, 0, 4'd0,    1};
        tbl[7]  = '{mk_ld(4'd7, 4'd2),                  0, 0, 0, 1, ALU_ADD, 1};
        tbl[8]  = '{mk_alu(ALU_SUB, 4'd8, 4'd1, 4'd7),  0, 0, 1, 0, 4'd0,    2};
        tbl[9]  = '{tbl[8].i,                           0, 0, 0, 1, ALU_SUB, 2};
        tbl[10] = '{add9,                               0, 0, 0, 1, ALU_ADD, 2};
        tbl[11] = '{sub10,                              0, 1, 1, 1, ALU_ADD, 2};
        tbl[12] = '{sub10,                              0, 1, 1, 1, ALU_ADD, 2};
        tbl[13] = '{sub10,                              1, 1, 1, 1, ALU_ADD, 2};
        tbl[14] = '{sub10,                              0, 0, 0, 1, ALU_SUB, 2};
        tbl[15] = '{nop,                                0, 0, 0, 0, 4'd0,    2};

        reset = 1'b1;
        drive(nop, 1'b0, 1'b0);
        m_ex = '0; m_valid = 1'b0; m_cnt = 0;
        #2;
        chk("reset ex_bundle", dut_bundle(), 128'(0));
        chk("reset ex_valid", 128'(bus.ex_valid), 128'(0));
        chk("reset hazard_count", 128'(bus.hazard_count), 128'(0));
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 16; k++) begin
            step(tbl[k].i, tbl[k].f, tbl[k].h, $sformatf("vec%0d", k), st);
            chk($sformatf("vec%0d tbl stall", k), 128'(st), 128'(tbl[k].stall));
            chk($sformatf("vec%0d tbl valid", k), 128'(bus.ex_valid), 128'(tbl[k].valid));
            chk($sformatf("vec%0d tbl alu", k), 128'(bus.ex_alu_op), 128'(tbl[k].alu));
            chk($sformatf("vec%0d tbl count", k), 128'(bus.hazard_count), 128'(tbl[k].cnt));
        end

        // Asynchronous reset while EX is full and a hold is requested.
        step(mk_ld(4'd2, 4'd0), 1'b0, 1'b0, "prereset", st);
        chk("prereset valid", 128'(bus.ex_valid), 128'(1));
        drive(add9, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async reset ex_bundle", dut_bundle(), 128'(0));
        chk("async reset ex_valid", 128'(bus.ex_valid), 128'(0));
        chk("async reset hazard_count", 128'(bus.hazard_count), 128'(0));
        chk("async reset id_stall", 128'(bus.id_stall), 128'(0));
        drive(nop, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_ex = '0; m_valid = 1'b0; m_cnt = 0;
        @(posedge clk);
        #1;

        // Drive the counter to all-ones, then one more hazard must not wrap.
        for (int n = 0; n < 16; n++) begin
            step(mk_ld(4'd15, 4'd0), 1'b0, 1'b0, "sat ld", st);
            step(mk_alu(ALU_SUB, 4'd1, 4'd15, 4'd15), 1'b0, 1'b0, "sat use", st);
            chk("sat stall", 128'(st), 128'(1));
            if (n == 14) chk("sat reach 15", 128'(bus.hazard_count), 128'(15));
            step(mk_alu(ALU_SUB, 4'd1, 4'd15, 4'd15), 1'b0, 1'b0, "sat go", st);
        end
        chk("sat hold at 15", 128'(bus.hazard_count), 128'(15));

        for (int n = 0; n < 400; n++) begin
            step(mk_rand(), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, "rand", st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
